// File: rtl/uart_rx_pkg.sv
// Shared types and parity helpers for the UART frame receiver.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP1,
      S_STOP2,
      S_WAIT_IDLE
   } rx_state_t;

   localparam logic [2:0] PAR_NONE   = 3'b000;
   localparam logic [2:0] PAR_ODD    = 3'b001;
   localparam logic [2:0] PAR_EVEN   = 3'b010;
   localparam logic [2:0] PAR_STICK0 = 3'b100;
   localparam logic [2:0] PAR_STICK1 = 3'b101;

   // Widest data word the parity helper accepts; callers zero-extend.
   localparam int PAR_DW = 16;

   function automatic logic parity_enabled(input logic [2:0] mode);
      return (mode == PAR_ODD) || (mode == PAR_EVEN) ||
             (mode == PAR_STICK0) || (mode == PAR_STICK1);
   endfunction

   function automatic logic parity_expected(input logic [2:0] mode,
                                            input logic [PAR_DW-1:0] data);
      logic p;
      p = 1'b0;
      case (mode)
         PAR_ODD:    p = ~(^data);
         PAR_EVEN:   p = ^data;
         PAR_STICK1: p = 1'b1;
         PAR_STICK0: p = 1'b0;
         PAR_NONE:   p = 1'b0;
         default:    p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every prescaler+1 clocks while enabled.
module uart_baud_tick (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] prescaler,
   output logic        tick
);

   logic [15:0] count;

   // >= rather than == so a prescaler lowered on the fly cannot strand the count above it.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         count <= '0;
      end else if (count >= prescaler) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign tick = en && (count >= prescaler);

endmodule

// File: rtl/uart_frame_rx.sv
// UART receiver: oversampled frame deserializer with error flags and a valid/ready output.
module uart_frame_rx
   import uart_rx_pkg::*;
#(
   parameter int MDW         = 9,
   parameter int OVS         = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [15:0]    prescaler,
   input  logic [3:0]     data_size,
   input  logic [2:0]     parity,
   input  logic           stop2,
   input  logic           rx,
   output logic [MDW-1:0] out_data,
   output logic           out_perr,
   output logic           out_ferr,
   output logic           out_brk,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           overrun,
   output logic           busy
);

   localparam int SW = $clog2(OVS);

   rx_state_t            state, state_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 rxs, rxs_d, fall;
   logic                 tick, mid, wrap;
   logic [SW-1:0]        s;
   logic [3:0]           bit_idx;
   logic [3:0]           size_eff;
   logic [3:0]           cfg_size;
   logic [2:0]           cfg_par;
   logic                 cfg_stop2;
   logic [MDW-1:0]       data_q;
   logic                 perr_acc, ferr_acc, brk_acc;
   logic                 start_go, complete;

   uart_baud_tick u_tick (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .prescaler (prescaler),
      .tick      (tick)
   );

   // Flops reset to 1 so the idle line does not look like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         rxs_d  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         rxs_d  <= rxs;
      end
   end

   assign rxs  = sync_q[SYNC_STAGES-1];
   assign fall = rxs_d && !rxs;
   assign mid  = tick && (s == SW'(OVS/2 - 1));
   assign wrap = tick && (s == SW'(OVS - 1));
   assign busy = (state != S_IDLE);

   always_comb begin
      size_eff = data_size;
      if (data_size < 4'd5) begin
         size_eff = 4'd5;
      end else if (data_size > 4'(MDW)) begin
         size_eff = 4'(MDW);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      start_go = 1'b0;
      complete = 1'b0;
      case (state)
         S_IDLE: begin
            if (fall) begin
               state_n  = S_START;
               start_go = 1'b1;
            end
         end
         S_START: begin
            if (mid && rxs) begin
               state_n = S_IDLE;
            end else if (wrap) begin
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (wrap && (bit_idx == cfg_size - 4'd1)) begin
               state_n = parity_enabled(cfg_par) ? S_PAR : S_STOP1;
            end
         end
         S_PAR: begin
            if (wrap) begin
               state_n = S_STOP1;
            end
         end
         S_STOP1: begin
            if (cfg_stop2) begin
               if (wrap) begin
                  state_n = S_STOP2;
               end
            end else if (mid) begin
               complete = 1'b1;
               state_n  = rxs ? S_IDLE : S_WAIT_IDLE;
            end
         end
         S_STOP2: begin
            if (mid) begin
               complete = 1'b1;
               state_n  = rxs ? S_IDLE : S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (rxs) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (!en) begin
         state_n  = S_IDLE;
         start_go = 1'b0;
         complete = 1'b0;
      end
   end

   // Frame datapath; brk_acc stays set only while every sampled bit has been 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         s         <= '0;
         bit_idx   <= '0;
         cfg_size  <= '0;
         cfg_par   <= '0;
         cfg_stop2 <= 1'b0;
         data_q    <= '0;
         perr_acc  <= 1'b0;
         ferr_acc  <= 1'b0;
         brk_acc   <= 1'b0;
         out_data  <= '0;
         out_perr  <= 1'b0;
         out_ferr  <= 1'b0;
         out_brk   <= 1'b0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (start_go) begin
            s         <= '0;
            bit_idx   <= '0;
            cfg_size  <= size_eff;
            cfg_par   <= parity;
            cfg_stop2 <= stop2;
            data_q    <= '0;
            perr_acc  <= 1'b0;
            ferr_acc  <= 1'b0;
            brk_acc   <= 1'b1;
         end else if (tick) begin
            s <= (s == SW'(OVS - 1)) ? '0 : s + SW'(1);
         end

         case (state)
            S_DATA: begin
               if (mid) begin
                  data_q  <= data_q | (MDW'(rxs) << bit_idx);
                  brk_acc <= brk_acc & ~rxs;
               end
               if (wrap) begin
                  bit_idx <= bit_idx + 4'd1;
               end
            end
            S_PAR: begin
               if (mid) begin
                  perr_acc <= rxs != parity_expected(cfg_par, PAR_DW'(data_q));
                  brk_acc  <= brk_acc & ~rxs;
               end
            end
            S_STOP1: begin
               if (mid) begin
                  ferr_acc <= ferr_acc | ~rxs;
                  brk_acc  <= brk_acc & ~rxs;
               end
            end
            S_STOP2: begin
               if (mid) begin
                  ferr_acc <= ferr_acc | ~rxs;
               end
            end
            default: ;
         endcase

         if (complete) begin
            if (!out_valid || out_ready) begin
               out_data  <= data_q;
               out_perr  <= perr_acc;
               out_ferr  <= ferr_acc | ~rxs;
               out_brk   <= (state == S_STOP1) ? (brk_acc & ~rxs) : brk_acc;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench: drives serial frames and compares against a frame-level model.
module tb_uart_frame_rx;

   localparam int MDW = 9;
   localparam int OVS = 8;

   typedef struct packed {
      logic       brk;
      logic       ferr;
      logic       perr;
      logic [8:0] data;
   } frame_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b1;
   logic [15:0]    prescaler = 16'd10;
   logic [3:0]     data_size = 4'd8;
   logic [2:0]     parity = 3'd0;
   logic           stop2 = 1'b0;
   logic           rx = 1'b1;
   logic           out_ready = 1'b1;
   logic [MDW-1:0] out_data;
   logic           out_perr, out_ferr, out_brk, out_valid, overrun, busy;

   int     checks = 0;
   int     failures = 0;
   int     ovr_count = 0;
   frame_t got_q[$];
   frame_t exp_q[$];

   always #5 clk = ~clk;

   uart_frame_rx #(.MDW(MDW), .OVS(OVS), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .prescaler (prescaler),
      .data_size (data_size),
      .parity    (parity),
      .stop2     (stop2),
      .rx        (rx),
      .out_data  (out_data),
      .out_perr  (out_perr),
      .out_ferr  (out_ferr),
      .out_brk   (out_brk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Record every accepted frame and every overrun pulse, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got_q.push_back({out_brk, out_ferr, out_perr, out_data});
         if (overrun) ovr_count++;
      end
   end

   function automatic int bit_clks();
      return (int'(prescaler) + 1) * OVS;
   endfunction

   function automatic int eff_size(input logic [3:0] ds);
      if (ds < 5) return 5;
      if (ds > MDW) return MDW;
      return int'(ds);
   endfunction

   function automatic bit par_on(input logic [2:0] p);
      return (p == 3'd1) || (p == 3'd2) || (p == 3'd4) || (p == 3'd5);
   endfunction

   // Parity bit a correct transmitter would send, from the count of ones.
   function automatic bit par_bit(input logic [2:0] p, input logic [8:0] d);
      case (p)
         3'd1:    return ($countones(d) % 2) == 0;
         3'd2:    return ($countones(d) % 2) == 1;
         3'd5:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive_level(input logic lv, input int n);
      rx = lv;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [8:0] d, input bit flip_par, input bit stop_low);
      int         n;
      logic [8:0] m;
      bit         pb;
      frame_t     e;
      n  = eff_size(data_size);
      m  = 9'(int'(d) & ((1 << n) - 1));
      pb = par_bit(parity, m) ^ flip_par;
      drive_level(1'b0, bit_clks());
      for (int i = 0; i < n; i++) drive_level(m[i], bit_clks());
      if (par_on(parity)) drive_level(pb, bit_clks());
      drive_level(!stop_low, bit_clks());
      if (stop2) drive_level(1'b1, bit_clks());
      e.data = m;
      e.perr = par_on(parity) && flip_par;
      e.ferr = stop_low;
      e.brk  = (m == 0) && (!par_on(parity) || !pb) && stop_low;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_perr, out_ferr, out_brk, overrun, busy} !== 6'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected 000000",
                  {out_valid, out_perr, out_ferr, out_brk, overrun, busy});
      end
      checks++;
      if (out_data !== 9'h000) begin
         failures++;
         $display("[TB] FAIL reset_data: got %h expected 000", out_data);
      end
      rst = 1'b0;
      drive_level(1'b1, 20);
   endtask

   task automatic test_8n1();
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0; out_ready = 1'b1;
      send_frame(9'h0A5, 1'b0, 1'b0);
      drive_level(1'b1, 2 * bit_clks());
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("[TB] FAIL 8n1_count: got %0d expected 1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin
            failures++;
            $display("[TB] FAIL 8n1_frame: got %h expected %h", got_q[0], exp_q[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      got_q.delete(); exp_q.delete(); ovr_count = 0;
      prescaler = 16'd21; data_size = 4'd8; parity = 3'b101; stop2 = 1'b1; out_ready = 1'b1;
      send_frame(9'h0C3, 1'b0, 1'b0);
      send_frame(9'h091, 1'b0, 1'b0);
      drive_level(1'b1, 2 * bit_clks());
      checks++;
      if (got_q.size() !== 2) begin
         failures++;
         $display("[TB] FAIL b2b_count: got %0d expected 2", got_q.size());
      end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL b2b_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (ovr_count !== 0) begin
         failures++;
         $display("[TB] FAIL b2b_overrun: got %0d expected 0", ovr_count);
      end
   endtask

   task automatic test_errors();
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd7; parity = 3'b010; stop2 = 1'b0; out_ready = 1'b1;
      send_frame(9'h055, 1'b1, 1'b0);
      drive_level(1'b1, bit_clks());
      send_frame(9'($urandom), 1'b0, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL err_wait_idle_busy: got %b expected 1", busy);
      end
      drive_level(1'b1, bit_clks());
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL err_recover_busy: got %b expected 0", busy);
      end
      send_frame(9'h02A, 1'b0, 1'b0);
      drive_level(1'b1, bit_clks());
      checks++;
      if (got_q.size() !== 3) begin
         failures++;
         $display("[TB] FAIL err_count: got %0d expected 3", got_q.size());
      end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL err_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_glitch();
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0;
      drive_level(1'b0, 2 * (int'(prescaler) + 1));
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL glitch_start_seen: got %b expected 1", busy);
      end
      drive_level(1'b1, 2 * bit_clks());
      checks++;
      if (busy !== 1'b0 || got_q.size() !== 0) begin
         failures++;
         $display("[TB] FAIL glitch_reject: got busy=%b frames=%0d expected busy=0 frames=0",
                  busy, got_q.size());
      end
   endtask

   task automatic test_break();
      frame_t e;
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0; out_ready = 1'b1;
      drive_level(1'b0, 3 * 10 * bit_clks());
      drive_level(1'b1, 2 * bit_clks());
      e.data = 9'h000; e.perr = 1'b0; e.ferr = 1'b1; e.brk = 1'b1;
      checks++;
      if (got_q.size() !== 1) begin
         failures++;
         $display("[TB] FAIL break_count: got %0d expected 1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== e) begin
            failures++;
            $display("[TB] FAIL break_frame: got %h expected %h", got_q[0], e);
         end
      end
   endtask

   task automatic test_overrun();
      got_q.delete(); exp_q.delete(); ovr_count = 0;
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0; out_ready = 1'b0;
      send_frame(9'h011, 1'b0, 1'b0);
      drive_level(1'b1, bit_clks());
      checks++;
      if (ovr_count !== 0 || out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ovr_first: got ovr=%0d valid=%b expected ovr=0 valid=1",
                  ovr_count, out_valid);
      end
      send_frame(9'h022, 1'b0, 1'b0);
      drive_level(1'b1, bit_clks());
      void'(exp_q.pop_back());
      checks++;
      if (ovr_count !== 1) begin
         failures++;
         $display("[TB] FAIL ovr_pulses: got %0d expected 1", ovr_count);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h011) begin
         failures++;
         $display("[TB] FAIL ovr_hold: got valid=%b data=%h expected valid=1 data=011",
                  out_valid, out_data);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ovr_drain: got valid=%b expected 0", out_valid);
      end
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("[TB] FAIL ovr_frame: got %0d frames first=%h expected 1 frame %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
      end
   endtask

   task automatic test_abort();
      logic [7:0] d;
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0; out_ready = 1'b1;
      d = 8'h3C;
      drive_level(1'b0, bit_clks());
      for (int i = 0; i < 3; i++) drive_level(d[i], bit_clks());
      en = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_busy: got %b expected 0", busy);
      end
      drive_level(1'b1, 2 * bit_clks());
      en = 1'b1;
      drive_level(1'b1, bit_clks());
      send_frame(9'h03C, 1'b0, 1'b0);
      drive_level(1'b1, bit_clks());
      checks++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("[TB] FAIL abort_resume: got %0d frames first=%h expected 1 frame %h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
      end
   endtask

   task automatic test_random();
      got_q.delete(); exp_q.delete(); ovr_count = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         prescaler = 16'($urandom_range(2, 8));
         data_size = 4'($urandom_range(0, 15));
         parity    = 3'($urandom_range(0, 7));
         stop2     = 1'($urandom_range(0, 1));
         drive_level(1'b1, bit_clks());
         send_frame(9'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
         drive_level(1'b1, 2 * bit_clks());
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("[TB] FAIL rand_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (ovr_count !== 0) begin
         failures++;
         $display("[TB] FAIL rand_overrun: got %0d expected 0", ovr_count);
      end
   endtask

   task automatic test_reset_midframe();
      got_q.delete(); exp_q.delete();
      prescaler = 16'd10; data_size = 4'd8; parity = 3'd0; stop2 = 1'b0; out_ready = 1'b0;
      send_frame(9'h05A, 1'b0, 1'b0);
      drive_level(1'b1, bit_clks());
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h05A) begin
         failures++;
         $display("[TB] FAIL rstmid_pending: got valid=%b data=%h expected valid=1 data=05a",
                  out_valid, out_data);
      end
      drive_level(1'b0, bit_clks());
      drive_level(1'b1, bit_clks() / 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_perr, out_ferr, out_brk, overrun, busy} !== 6'b0 || out_data !== 9'h000) begin
         failures++;
         $display("[TB] FAIL rstmid_clear: got flags=%b data=%h expected flags=000000 data=000",
                  {out_valid, out_perr, out_ferr, out_brk, overrun, busy}, out_data);
      end
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      $display("[TB] uart_frame_rx bench starting");
      test_reset();
      test_8n1();
      test_back_to_back();
      test_errors();
      test_glitch();
      test_break();
      test_overrun();
      test_abort();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
